// File: rtl/adc_stream_framer.sv
// Frames a registered ADC sample stream into AXI4-Stream packets of programmable length.
// A FWFT FIFO plus one output register absorbs downstream backpressure; overflowing samples are counted.
module adc_stream_framer #(
    parameter int ADC_DWIDTH = 256,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    capture_en_i,
    input  logic                    continuous_i,
    input  logic [LEN_WIDTH-1:0]    length_i,
    input  logic                    clear_i,
    input  logic [ADC_DWIDTH-1:0]   adc_data_i,
    input  logic                    adc_data_valid_i,
    input  logic                    m_axis_adc_tready,
    output logic                    m_axis_adc_tvalid,
    output logic [ADC_DWIDTH-1:0]   m_axis_adc_tdata,
    output logic [ADC_DWIDTH/8-1:0] m_axis_adc_tkeep,
    output logic                    m_axis_adc_tlast,
    output logic                    m_axis_adc_tuser,
    output logic                    busy_o,
    output logic                    overflow_o,
    output logic [31:0]             drop_cnt_o,
    output logic [31:0]             frame_cnt_o,
    output logic [1:0]              dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = ADC_DWIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADC_DWIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  cap_q;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  beat_cnt;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_cnt;
    logic [AW:0]           total_cnt;

    logic                  out_valid;
    logic [ADC_DWIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_user;

    logic                  wr_en;
    logic                  drop;
    logic                  frame_start;
    logic                  first_beat;
    logic                  last_beat;
    logic                  full;
    logic                  pop;
    logic                  last_handshake;

    // All capture decisions are taken on these registered copies.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            data_q  <= adc_data_i;
            valid_q <= adc_data_valid_i;
            cap_q   <= capture_en_i;
        end
    end

    // Occupancy counts the output register, and is sampled before this cycle's read.
    assign total_cnt  = fifo_cnt + (AW+1)'(out_valid);
    assign full       = (total_cnt == (AW+1)'(FIFO_DEPTH));
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == len_q);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cap_q) state_d = S_RUN;
            S_RUN:   if (wr_en && last_beat && !(continuous_i && cap_q)) state_d = S_DRAIN;
            S_DRAIN: if (total_cnt == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en       = 1'b0;
        drop        = 1'b0;
        frame_start = 1'b0;
        if (state_q == S_RUN && valid_q) begin
            if (full) drop = 1'b1;
            else      wr_en = 1'b1;
        end
        if (state_q == S_IDLE && cap_q) frame_start = 1'b1;
        if (wr_en && last_beat && continuous_i && cap_q) frame_start = 1'b1;
    end

    // A drop never advances beat_cnt, so every frame carries exactly len_q+1 beats.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            len_q    <= '0;
            beat_cnt <= '0;
        end else if (frame_start) begin
            len_q    <= length_i;
            beat_cnt <= '0;
        end else if (wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= {first_beat, last_beat, data_q};
    end

    assign pop = (fifo_cnt != '0) && (!out_valid || m_axis_adc_tready);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!wr_en && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Handshake: a beat transfers on a clock edge where tvalid && tready; tvalid is a
    // register that never looks at tready combinationally, and the beat is frozen until taken.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
        end else if (pop) begin
            out_valid                      <= 1'b1;
            {out_user, out_last, out_data} <= mem[rd_ptr];
        end else if (m_axis_adc_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign last_handshake = out_valid && m_axis_adc_tready && out_last;

    // Clear takes priority over a same-cycle drop or frame completion.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_o  <= 1'b0;
            drop_cnt_o  <= '0;
            frame_cnt_o <= '0;
        end else if (clear_i) begin
            overflow_o  <= 1'b0;
            drop_cnt_o  <= '0;
            frame_cnt_o <= '0;
        end else begin
            if (drop) overflow_o <= 1'b1;
            if (drop && drop_cnt_o != 32'hFFFF_FFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
            if (last_handshake) frame_cnt_o <= frame_cnt_o + 1'b1;
        end
    end

    assign m_axis_adc_tvalid = out_valid;
    assign m_axis_adc_tdata  = out_data;
    assign m_axis_adc_tlast  = out_last;
    assign m_axis_adc_tuser  = out_user;
    assign m_axis_adc_tkeep  = '1;
    assign busy_o            = (state_q != S_IDLE) || (total_cnt != '0);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_adc_stream_framer.sv
// Directed bench for adc_stream_framer: framing, backpressure, drops, continuous mode, clear and reset.
module tb_adc_stream_framer;

    localparam int DW = 64;
    localparam int FD = 16;
    localparam int LW = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;

    logic          clk = 1'b0;
    logic          reset_ni = 1'b0;
    logic          capture_en = 1'b0;
    logic          continuous = 1'b0;
    logic [LW-1:0] length = '0;
    logic          clear = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          tready = 1'b1;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tkeep;
    logic          tlast;
    logic          tuser;
    logic          busy;
    logic          overflow;
    logic [31:0]   drop_cnt;
    logic [31:0]   frame_cnt;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;

    logic [DW+1:0] exp_q[$];

    adc_stream_framer #(
        .ADC_DWIDTH(DW),
        .FIFO_DEPTH(FD),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .capture_en_i     (capture_en),
        .continuous_i     (continuous),
        .length_i         (length),
        .clear_i          (clear),
        .adc_data_i       (adc_data),
        .adc_data_valid_i (adc_valid),
        .m_axis_adc_tready(tready),
        .m_axis_adc_tvalid(tvalid),
        .m_axis_adc_tdata (tdata),
        .m_axis_adc_tkeep (tkeep),
        .m_axis_adc_tlast (tlast),
        .m_axis_adc_tuser (tuser),
        .busy_o           (busy),
        .overflow_o       (overflow),
        .drop_cnt_o       (drop_cnt),
        .frame_cnt_o      (frame_cnt),
        .dbg_state        (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_samples(input int n, input logic [DW-1:0] base, input bit cap_off_on_last);
        for (int i = 0; i < n; i++) begin
            adc_data  = base + DW'(i);
            adc_valid = 1'b1;
            if (cap_off_on_last && i == n - 1) capture_en = 1'b0;
            tick(1);
        end
        adc_valid = 1'b0;
    endtask

    task automatic expect_beat(input logic [DW-1:0] data, input logic user, input logic last);
        exp_q.push_back({user, last, data});
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
        int n = 0;
        while (dbg_state !== target && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, dbg_state, target);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Scoreboard / monitor: beats compared at the falling edge, stalls must hold the beat.
    logic [DW+2:0] prev_beat;
    logic          prev_stall = 1'b0;
    logic [DW+1:0] head;

    always @(negedge clk) begin
        if (!reset_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {tvalid, tuser, tlast, tdata}, prev_beat);
            if (tvalid && tready) begin
                check("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    check("beat", {tuser, tlast, tdata}, head);
                end
            end
            prev_stall = tvalid && !tready;
            prev_beat  = {tvalid, tuser, tlast, tdata};
        end
    end

    initial begin
        // Reset state without any clock edge
        #2;
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tdata", tdata, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_counts", {overflow, drop_cnt, frame_cnt}, '0);
        check("rst_state", dbg_state, ST_IDLE);
        check("tkeep", tkeep, 8'hFF);
        #10;
        reset_ni = 1'b1;
        tick(1);

        // 1: single 4-beat frame, later samples ignored
        length = 3; continuous = 1'b0; tready = 1'b1; capture_en = 1'b1;
        wait_state("t1_run", ST_RUN, 10);
        for (int i = 0; i < 4; i++) expect_beat(64'hA0 + 64'(i), i == 0, i == 3);
        send_samples(4, 64'hA0, 1'b1);
        wait_idle("t1_idle", 30);
        check("t1_frames", frame_cnt, 32'd1);
        check("t1_state", dbg_state, ST_IDLE);
        send_samples(3, 64'hAF, 1'b0);
        tick(5);
        check("t1_ignored_frames", frame_cnt, 32'd1);
        check("t1_sb_empty", exp_q.size(), 0);

        // 2: 8-beat frame with 10 stalled cycles, no drops
        length = 7; tready = 1'b0; capture_en = 1'b1;
        wait_state("t2_run", ST_RUN, 10);
        for (int i = 0; i < 8; i++) expect_beat(64'hB0 + 64'(i), i == 0, i == 7);
        send_samples(8, 64'hB0, 1'b1);
        tick(2);
        check("t2_stalled_tvalid", tvalid, 1'b1);
        tready = 1'b1;
        wait_idle("t2_idle", 40);
        check("t2_frames", frame_cnt, 32'd2);
        check("t2_drops", {overflow, drop_cnt}, 33'd0);
        check("t2_sb_empty", exp_q.size(), 0);

        // 3: overflow, 20 samples into 16 entries, frame ends after 32 accepted beats
        length = 31; tready = 1'b0; capture_en = 1'b1;
        wait_state("t3_run", ST_RUN, 10);
        for (int i = 0; i < 16; i++) expect_beat(64'hC00 + 64'(i), i == 0, 1'b0);
        send_samples(20, 64'hC00, 1'b0);
        tick(3);
        check("t3_drop_cnt", drop_cnt, 32'd4);
        check("t3_overflow", overflow, 1'b1);
        check("t3_still_run", dbg_state, ST_RUN);
        tready = 1'b1;
        tick(3);
        for (int i = 0; i < 16; i++) expect_beat(64'hD00 + 64'(i), 1'b0, i == 15);
        send_samples(16, 64'hD00, 1'b1);
        wait_idle("t3_idle", 60);
        check("t3_frames", frame_cnt, 32'd3);
        check("t3_drop_final", drop_cnt, 32'd4);
        check("t3_sb_empty", exp_q.size(), 0);

        // 4: continuous 2-beat frames
        length = 1; continuous = 1'b1; capture_en = 1'b1;
        wait_state("t4_run", ST_RUN, 10);
        for (int i = 0; i < 6; i++) expect_beat(64'hE0 + 64'(i), (i % 2) == 0, (i % 2) == 1);
        send_samples(6, 64'hE0, 1'b1);
        continuous = 1'b0;
        wait_idle("t4_idle", 30);
        check("t4_frames", frame_cnt, 32'd6);
        check("t4_sb_empty", exp_q.size(), 0);

        // 5: capture dropped mid-frame, frame still completes; then clear
        length = 4; capture_en = 1'b1;
        wait_state("t5_run", ST_RUN, 10);
        for (int i = 0; i < 5; i++) expect_beat(64'hF0 + 64'(i), i == 0, i == 4);
        send_samples(2, 64'hF0, 1'b0);
        capture_en = 1'b0;
        tick(3);
        check("t5_run_hold", dbg_state, ST_RUN);
        send_samples(3, 64'hF2, 1'b0);
        wait_idle("t5_idle", 30);
        check("t5_frames", frame_cnt, 32'd7);
        check("t5_state", dbg_state, ST_IDLE);
        check("t5_sb_empty", exp_q.size(), 0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t5_clear", {overflow, drop_cnt, frame_cnt}, '0);

        // 6: reset while a beat is presented, then a clean frame with latency check
        length = 5; tready = 1'b0; capture_en = 1'b1;
        wait_state("t6_run", ST_RUN, 10);
        send_samples(2, 64'h100, 1'b0);
        tick(3);
        check("t6_pre_tvalid", tvalid, 1'b1);
        #2;
        reset_ni = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_tvalid", tvalid, 1'b0);
        check("t6_rst_beat", {tuser, tlast, tdata}, '0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        #2;
        length = 1; tready = 1'b1;
        reset_ni = 1'b1;
        tick(1);
        wait_state("t6_run2", ST_RUN, 10);
        expect_beat(64'h200, 1'b1, 1'b0);
        expect_beat(64'h201, 1'b0, 1'b1);
        adc_data = 64'h200; adc_valid = 1'b1;
        tick(1);
        adc_data = 64'h201; capture_en = 1'b0;
        check("t6_lat_k", tvalid, 1'b0);
        tick(1);
        adc_valid = 1'b0;
        check("t6_lat_k1", tvalid, 1'b0);
        tick(1);
        check("t6_lat_k2", tvalid, 1'b1);
        wait_idle("t6_idle", 30);
        check("t6_frames", frame_cnt, 32'd1);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_stream_framer.md
# adc_stream_framer

Parametrised ADC-to-AXI4-Stream framer that sits between the ADC capture front end and the AXI DMA S2MM stream port. It cuts the continuous ADC sample stream into frames of programmable length, with a start-of-frame marker and `tlast` on the final beat. An internal FIFO absorbs DMA backpressure, so samples are never silently corrupted. It supports single-shot and continuous capture modes, and reports drops and completed frames through status counters.

## Interface
Parameters:
- ADC_DWIDTH, 256, width of one ADC sample word / stream beat; multiple of 8
- FIFO_DEPTH, 16, total beat storage including the output register; power of 2, >= 4
- LEN_WIDTH, 32, width of the frame length input

Ports:
- clk_i  in  1  single clock for all logic
- reset_ni  in  1  asynchronous, active-low reset
- capture_en_i  in  1  level enable; start/continue capture
- continuous_i  in  1  1 = back-to-back frames while capture_en_i is high; 0 = single frame
- length_i  in  LEN_WIDTH  beats per frame minus 1; latched at frame start
- clear_i  in  1  synchronous clear of overflow_o, drop_cnt_o, frame_cnt_o
- adc_data_i  in  ADC_DWIDTH  ADC sample word
- adc_data_valid_i  in  1  sample qualifier
- m_axis_adc_tready  in  1  downstream ready
- m_axis_adc_tvalid  out  1  beat valid
- m_axis_adc_tdata  out  ADC_DWIDTH  beat data
- m_axis_adc_tkeep  out  ADC_DWIDTH/8  constant all ones
- m_axis_adc_tlast  out  1  last beat of frame
- m_axis_adc_tuser  out  1  first beat of frame (SOF)
- busy_o  out  1  state != IDLE or buffer non-empty
- overflow_o  out  1  sticky; set on any dropped sample
- drop_cnt_o  out  32  dropped samples, saturating at 0xFFFFFFFF
- frame_cnt_o  out  32  frames completed (tlast handshakes), wrapping

## Operation
- Input stage: adc_data_i, adc_data_valid_i and capture_en_i are registered once. All decisions use the registered copies.
- Each FIFO entry stores {tuser, tlast, tdata}. The FIFO is first-word-fall-through into the output register.
- beat_cnt (LEN_WIDTH bits) counts accepted beats within the frame. len_q holds the latched length_i.
- States:
  - IDLE: if capture_en is high, latch len_q <= length_i, set beat_cnt <= 0, go to RUN. Samples arriving in IDLE are ignored and are not counted as drops.
  - RUN: each valid sample with buffer not full is written with tuser = (beat_cnt==0) and tlast = (beat_cnt==len_q). beat_cnt then increments.
    - On the write with tlast=1: if continuous_i && capture_en, relatch len_q from length_i, set beat_cnt <= 0, and stay in RUN. Otherwise go to DRAIN.
    - Dropping capture_en mid-frame does not truncate the frame; the frame completes.
  - DRAIN: no writes. Go to IDLE when the buffer is empty and no beat is pending on the output.
- Drop rule: a valid sample in RUN while the buffer is full (FIFO_DEPTH entries held) is discarded.
  - beat_cnt does not advance on a drop, so frame length is always exactly len_q+1 beats.
  - Fullness is evaluated before same-cycle reads: a write is dropped even if a handshake frees a slot that cycle.
  - Each drop sets overflow_o and increments drop_cnt_o.
- clear_i wins over a same-cycle drop or frame completion (counters read 0 the next cycle).
- length_i = 0 gives 1-beat frames: tuser and tlast are both high on the same beat.

## Timing
- Reset (asynchronous assert, synchronous deassert handled externally) forces the following immediately:
  - tvalid=0, tlast=0, tuser=0, tdata=0
  - busy_o=0, overflow_o=0, drop_cnt_o=0, frame_cnt_o=0
  - state IDLE, FIFO empty
- Reset mid-frame discards all buffered beats. No partial frame is completed.
- Latency: a sample presented at edge k with an empty buffer appears with tvalid=1 after edge k+2.
- AXIS rules:
  - tvalid never depends combinationally on tready.
  - Once tvalid=1, tdata, tlast and tuser are held stable until the tready handshake.
  - Throughput is 1 beat/cycle sustained when tready=1.
- IDLE->RUN takes 1 cycle after registered capture_en is seen. The first accepted sample is the one valid in the cycle after entry.
- frame_cnt_o updates the cycle after the tlast handshake.

## Test plan
- length_i=3, continuous_i=0, tready=1, 4 samples D0..D3 -> 4 beats in order; tuser on D0, tlast on D3; frame_cnt_o=1; busy_o=0 afterwards; later samples ignored.
- length_i=7, FIFO_DEPTH=16, tready low for 10 cycles during capture -> no drops; order preserved; tdata/tlast held stable while stalled.
- tready low, 20 samples in RUN with length_i=31, FIFO_DEPTH=16 -> drop_cnt_o=4, overflow_o=1; after release 16 beats emerge; the frame still ends after 32 accepted beats.
- continuous_i=1, capture_en_i high, length_i=1, 6 samples -> 3 frames; tuser on beats 1,3,5; tlast on beats 2,4,6; frame_cnt_o=3.
- capture_en_i dropped after beat 2 of a length_i=4 frame -> frame completes with 5 beats, then DRAIN->IDLE; clear_i then zeroes all counters.
- reset_ni asserted with tvalid=1 mid-frame -> all outputs 0 without a clock edge; after release, a new frame starts clean with tuser on its first beat.
